// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-outstanding instruction fetch sequencer
// Optional FETCH_PERF_CNT_EN adds FetchCount/StallCount performance counters.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [63:0] NextPC,
    input  logic        InstrAccept,
    input  logic        Stall,
    input  logic        IMemReqReady,
    input  logic        IMemRspValid,
    input  logic [31:0] IMemRspData,
    output logic [63:0] CurrentPC,
    output logic        IMemReqValid,
    output logic [63:0] IMemAddr,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic        FetchFault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic [2:0] state;
    logic       accept;

    // NextPC is only looked at inside an accept, so X on it elsewhere is harmless
    assign accept       = (state == ST_HOLD) && InstrAccept && !Stall;

    assign IMemReqValid = (state == ST_REQ);
    assign IMemAddr     = CurrentPC;
    assign InstrValid   = (state == ST_HOLD);
    assign FetchFault   = (state == ST_FAULT);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= ST_IDLE;
            CurrentPC   <= RESET_PC;
            Instruction <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (IMemReqReady) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (IMemRspValid) begin
                        Instruction <= IMemRspData;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        if (NextPC[1:0] == 2'b00) begin
                            CurrentPC <= NextPC;
                            state     <= ST_REQ;
                        end else begin
                            state     <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            FetchCount <= 32'h0;
            StallCount <= 32'h0;
        end else begin
            if (accept && (NextPC[1:0] == 2'b00)) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if ((state == ST_HOLD) && Stall) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the single-cycle datapath. It consumes the NextPC value produced by the next-PC logic and owns CurrentPC. It issues one instruction-memory request at a time through a valid/ready handshake and holds the returned instruction until the datapath accepts it. Misaligned targets raise a sticky fault.

Parameters:
RESET_PC, 64'h0, CurrentPC value loaded on reset; must be 4-byte aligned.

Ports:
CLK  input  1  clock, rising edge
Reset_L  input  1  asynchronous, active-low reset
NextPC  input  64  next PC from the next-PC logic; sampled only on an accept cycle
InstrAccept  input  1  datapath consumes Instruction this cycle
Stall  input  1  datapath stall; blocks accept
IMemReqReady  input  1  instruction memory accepts request
IMemRspValid  input  1  instruction memory response valid
IMemRspData  input  32  instruction word
CurrentPC  output  64  PC of the instruction being fetched or held
IMemReqValid  output  1  request valid
IMemAddr  output  64  request address, equal to CurrentPC
InstrValid  output  1  Instruction holds a valid word
Instruction  output  32  held instruction word
FetchFault  output  1  sticky misaligned-target fault

Behaviour:
- Reset (Reset_L=0, asynchronous):
  - CurrentPC=RESET_PC; Instruction=0.
  - InstrValid=0, IMemReqValid=0, FetchFault=0.
  - State=IDLE.
  - Reset asserted mid-transaction abandons it. Any later response is ignored until the unit is back in WAIT.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: outputs idle; moves to REQ on the first clock edge after Reset_L deasserts.
- REQ:
  - IMemReqValid=1, IMemAddr=CurrentPC.
  - IMemReqValid and IMemAddr stay stable until IMemReqReady=1.
  - On Valid&Ready, go to WAIT.
- WAIT:
  - IMemReqValid=0.
  - On IMemRspValid=1, Instruction<=IMemRspData and go to HOLD.
  - Only one request is outstanding.
  - IMemRspValid in any other state is ignored, so minimum response latency is 1 cycle after the request handshake.
- HOLD:
  - InstrValid=1; Instruction and CurrentPC are stable.
  - An accept occurs when InstrAccept=1 and Stall=0.
  - Accept with NextPC[1:0]==0: CurrentPC<=NextPC, InstrValid<=0, go to REQ. The new request is driven in the cycle after the accept.
  - Accept with NextPC[1:0]!=0: CurrentPC unchanged, InstrValid<=0, FetchFault<=1, go to FAULT.
  - InstrAccept=1 together with Stall=1: no accept; remain in HOLD.
- FAULT:
  - Terminal; no requests issued, InstrValid=0, FetchFault=1.
  - Exits only by reset.
- Arithmetic: NextPC is registered unmodified, full 64 bits. Wrap-around past 2^64 is the next-PC logic's responsibility; the unit applies no range check.
- Throughput: at best 1 instruction per 3 cycles (REQ, WAIT, HOLD) with Ready=1 and 1-cycle response latency.
- X on NextPC outside an accept cycle must not affect state.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output FetchCount[31:0], reset to 0.
  - Increments by 1 on every accept that does not fault; wraps from 32'hFFFFFFFF to 0.
  - Adds output StallCount[31:0], reset to 0. Increments each cycle in HOLD with Stall=1; also wraps.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=64'h100, Ready=1, 1-cycle response 32'h8B020020, InstrAccept=1, NextPC=64'h104 -> cycle after reset release IMemReqValid=1 with IMemAddr=64'h100. Instruction=32'h8B020020 with InstrValid=1 one cycle after the response. CurrentPC becomes 64'h104 after accept; next request targets 64'h104.
- Branch: in HOLD at PC 64'h104, NextPC=64'h104+(64'hFFFFFFFFFFFFFFFE<<2)=64'hFC, accept -> next IMemAddr=64'hFC.
- Backpressure: IMemReqReady low for 5 cycles -> IMemReqValid stays 1 and IMemAddr stays constant for all 5 cycles. A spurious IMemRspValid during REQ is ignored (Instruction unchanged).
- Stall: HOLD with InstrAccept=1, Stall=1 for 3 cycles -> CurrentPC and Instruction unchanged, InstrValid=1. With FETCH_PERF_CNT_EN, StallCount=3. Drop Stall -> accept.
- Misaligned: accept with NextPC=64'h10A -> FetchFault=1, IMemReqValid stays 0 indefinitely, CurrentPC keeps its old value. Reset_L pulse -> FetchFault=0, fetch restarts at RESET_PC.
- Reset during WAIT, with the memory response arriving after reset release but before the new request -> response ignored. InstrValid=0; the first request after reset targets RESET_PC.
